// File: rtl/fpu_ctrl_pkg.sv
// Shared definitions for the FPU Wishbone sequencer.
// Contents: register offsets inside the 0x40 window, STATUS / sticky-flag bit indices,
// FSM state type, one-hot FPU op codes and a byte-lane merge helper for bus writes.
package fpu_ctrl_pkg;

  // Register offsets (byte addresses inside the window)
  localparam logic [5:0] OffA      = 6'h00;
  localparam logic [5:0] OffB      = 6'h04;
  localparam logic [5:0] OffC      = 6'h08;
  localparam logic [5:0] OffResult = 6'h0C;
  localparam logic [5:0] OffFlags  = 6'h10;
  localparam logic [5:0] OffStatus = 6'h14;
  localparam logic [5:0] OffCtrl   = 6'h18;
  localparam logic [5:0] OffOp     = 6'h1C;
  localparam logic [5:0] OffRm     = 6'h24;

  // STATUS register bit positions
  localparam int unsigned StatBusy    = 0;
  localparam int unsigned StatDone    = 1;
  localparam int unsigned StatErrBusy = 2;
  localparam int unsigned StatErrOp   = 3;
  localparam int unsigned StatTimeout = 4;

  // Sticky flag vector held by the sequencer FSM; maps onto STATUS[4:1]
  localparam int unsigned NumSticky = 4;
  localparam int unsigned FlDone    = 0;
  localparam int unsigned FlErrBusy = 1;
  localparam int unsigned FlErrOp   = 2;
  localparam int unsigned FlTimeout = 3;

  // Start bit in the OP register write data
  localparam int unsigned OpStartBit = 12;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } seq_state_e;

  // One-hot FPU operation codes
  localparam logic [11:0] OpAdd  = 12'h001;
  localparam logic [11:0] OpSub  = 12'h002;
  localparam logic [11:0] OpMul  = 12'h004;
  localparam logic [11:0] OpDiv  = 12'h008;
  localparam logic [11:0] OpMac  = 12'h010;
  localparam logic [11:0] OpSqrt = 12'h020;
  localparam logic [11:0] OpMin  = 12'h040;
  localparam logic [11:0] OpMax  = 12'h080;
  localparam logic [11:0] OpCmp  = 12'h100;
  localparam logic [11:0] OpF2i  = 12'h200;
  localparam logic [11:0] OpI2f  = 12'h400;
  localparam logic [11:0] OpSgnj = 12'h800;

  // Replace only the byte lanes selected by sel
  function automatic logic [31:0] wb_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/fpu_wb_sequencer_if.sv
// Wishbone classic slave bus bundle for the FPU sequencer.
// Signal suffixes are from the slave's point of view.
//   wbs_stb_i/cyc_i/we_i  strobe, cycle, write enable
//   wbs_sel_i             byte lanes
//   wbs_adr_i/dat_i       address and write data
//   wbs_ack_o/dat_o       acknowledge and read data
interface fpu_wb_sequencer_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/fpu_seq_fsm.sv
// Launch sequencer for the FPU: IDLE -> ISSUE -> WAIT -> IDLE, WAIT timeout counter and
// the sticky done / err_busy / err_op / timeout flags.
//   clk_i, rst_i     clock, synchronous active-high reset
//   start_i          start request decoded from an OP write (only while idle)
//   op_i             op value being written with that request
//   busy_wr_i        a config write arrived while busy
//   w1c_i            write-one-to-clear mask for the sticky flags
//   fpu_valid_i      FPU result strobe
//   busy_o           sequencer is in ISSUE or WAIT
//   fpu_valid_o      one-cycle launch strobe (ISSUE state)
//   launch_o         accepted start this cycle (clear FLAGS)
//   capture_o        result accepted this cycle (capture RESULT/FLAGS)
//   sticky_o         {timeout, err_op, err_busy, done}
module fpu_seq_fsm
  import fpu_ctrl_pkg::*;
#(
  parameter int unsigned OP_W        = 12,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [OP_W-1:0]      op_i,
  input  logic                 busy_wr_i,
  input  logic [NumSticky-1:0] w1c_i,
  input  logic                 fpu_valid_i,
  output logic                 busy_o,
  output logic                 fpu_valid_o,
  output logic                 launch_o,
  output logic                 capture_o,
  output logic [NumSticky-1:0] sticky_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  seq_state_e           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [NumSticky-1:0] sticky_q, sticky_d;
  logic [NumSticky-1:0] set_flags;
  logic                 clr_done;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    launch_o  = 1'b0;
    capture_o = 1'b0;
    set_flags = '0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if ($countones(op_i) == 1) begin
            state_d  = StIssue;
            launch_o = 1'b1;
          end else begin
            set_flags[FlErrOp] = 1'b1;
          end
        end
      end
      StIssue: begin
        state_d = StWait;
        cnt_d   = '0;
      end
      StWait: begin
        if (fpu_valid_i) begin
          capture_o          = 1'b1;
          set_flags[FlDone]  = 1'b1;
          state_d            = StIdle;
        end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
          // This is the last of TIMEOUT_CYC cycles spent waiting with no result
          set_flags[FlTimeout] = 1'b1;
          state_d              = StIdle;
        end else if (cnt_q != CntW'(TIMEOUT_CYC)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    set_flags[FlErrBusy] = busy_wr_i;

    // A launch clears done; a hardware set always beats a same-cycle W1C
    clr_done          = launch_o;
    sticky_d          = sticky_q & ~w1c_i;
    sticky_d[FlDone]  = sticky_d[FlDone] & ~clr_done;
    sticky_d          = sticky_d | set_flags;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      sticky_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign fpu_valid_o = (state_q == StIssue);
  assign sticky_o    = sticky_q;

endmodule

// File: rtl/fpu_wb_sequencer.sv
// Wishbone slave that owns the FPU: operand/op/rounding-mode registers, result and
// exception-flag capture, status reporting and a completion interrupt.
//   wb_clk_i, wb_rst_i   clock, synchronous active-high reset
//   wbs                  Wishbone slave bundle (window BASE_ADDR .. BASE_ADDR+0x3F)
//   fpu_a/b/c_o          operand registers
//   fpu_op_o, fpu_rm_o   one-hot op and rounding mode registers
//   fpu_valid_o          one-cycle launch strobe
//   fpu_result_i/flags_i/valid_i  FPU response
//   irq_o                level interrupt: done & IE
module fpu_wb_sequencer
  import fpu_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned OP_W        = 12,  // 9..16 (two byte lanes)
  parameter int unsigned FLAG_W      = 5,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  fpu_wb_sequencer_if.slave   wbs,
  output logic [31:0]         fpu_a_o,
  output logic [31:0]         fpu_b_o,
  output logic [31:0]         fpu_c_o,
  output logic [OP_W-1:0]     fpu_op_o,
  output logic [2:0]          fpu_rm_o,
  output logic                fpu_valid_o,
  input  logic [31:0]         fpu_result_i,
  input  logic [FLAG_W-1:0]   fpu_flags_i,
  input  logic                fpu_valid_i,
  output logic                irq_o
);

  logic [31:0]          a_q, a_d, b_q, b_d, c_q, c_d;
  logic [31:0]          result_q, result_d;
  logic [FLAG_W-1:0]    flags_q, flags_d;
  logic [OP_W-1:0]      op_q, op_d, op_new;
  logic [2:0]           rm_q, rm_d;
  logic                 ie_q, ie_d;
  logic                 ack_q, ack_d;
  logic [31:0]          dat_q, dat_d;

  logic [5:0]           off;
  logic                 in_win, req, wr, rd;
  logic                 busy, cfg_hit;
  logic                 start_req, busy_wr;
  logic [NumSticky-1:0] w1c, sticky;
  logic                 launch, capture;
  logic [31:0]          rdata;

  assign off    = wbs.wbs_adr_i[5:0];
  assign in_win = (wbs.wbs_adr_i[31:6] == BASE_ADDR[31:6]);
  // Gating on ack_q keeps ack to a single cycle while the master still holds stb
  assign req    = wbs.wbs_stb_i & wbs.wbs_cyc_i & in_win & ~ack_q;
  assign wr     = req & wbs.wbs_we_i;
  assign rd     = req & ~wbs.wbs_we_i;

  assign cfg_hit = (off == OffA) || (off == OffB) || (off == OffC) ||
                   (off == OffOp) || (off == OffRm);
  assign busy_wr = wr & busy & cfg_hit;

  // OP spans lanes 0 and 1
  always_comb begin
    op_new = op_q;
    if (wbs.wbs_sel_i[0]) op_new[7:0]      = wbs.wbs_dat_i[7:0];
    if (wbs.wbs_sel_i[1]) op_new[OP_W-1:8] = wbs.wbs_dat_i[OP_W-1:8];
  end

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    op_d      = op_q;
    rm_d      = rm_q;
    ie_d      = ie_q;
    result_d  = result_q;
    flags_d   = flags_q;
    w1c       = '0;
    start_req = 1'b0;

    if (wr) begin
      case (off)
        OffA:   if (!busy) a_d = wb_merge(a_q, wbs.wbs_dat_i, wbs.wbs_sel_i);
        OffB:   if (!busy) b_d = wb_merge(b_q, wbs.wbs_dat_i, wbs.wbs_sel_i);
        OffC:   if (!busy) c_d = wb_merge(c_q, wbs.wbs_dat_i, wbs.wbs_sel_i);
        OffOp: begin
          if (!busy) begin
            op_d      = op_new;
            start_req = wbs.wbs_sel_i[1] & wbs.wbs_dat_i[OpStartBit];
          end
        end
        OffRm:  if (!busy && wbs.wbs_sel_i[0]) rm_d = wbs.wbs_dat_i[2:0];
        OffCtrl: if (wbs.wbs_sel_i[0]) ie_d = wbs.wbs_dat_i[0];
        OffStatus: begin
          if (wbs.wbs_sel_i[0]) w1c = wbs.wbs_dat_i[StatTimeout:StatDone];
        end
        default: ;
      endcase
    end

    if (launch) flags_d = '0;
    if (capture) begin
      result_d = fpu_result_i;
      flags_d  = fpu_flags_i;
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      OffA:      rdata = a_q;
      OffB:      rdata = b_q;
      OffC:      rdata = c_q;
      OffResult: rdata = result_q;
      OffFlags:  rdata[FLAG_W-1:0] = flags_q;
      OffStatus: rdata[StatTimeout:StatBusy] = {sticky, busy};
      OffCtrl:   rdata[0] = ie_q;
      OffOp:     rdata[OP_W-1:0] = op_q;
      OffRm:     rdata[2:0] = rm_q;
      default:   ;
    endcase
    ack_d = req;
    dat_d = rd ? rdata : '0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      op_q     <= '0;
      rm_q     <= '0;
      ie_q     <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      op_q     <= op_d;
      rm_q     <= rm_d;
      ie_q     <= ie_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
    end
  end

  fpu_seq_fsm #(
    .OP_W        (OP_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_fsm (
    .clk_i       (wb_clk_i),
    .rst_i       (wb_rst_i),
    .start_i     (start_req),
    .op_i        (op_new),
    .busy_wr_i   (busy_wr),
    .w1c_i       (w1c),
    .fpu_valid_i (fpu_valid_i),
    .busy_o      (busy),
    .fpu_valid_o (fpu_valid_o),
    .launch_o    (launch),
    .capture_o   (capture),
    .sticky_o    (sticky)
  );

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign fpu_a_o       = a_q;
  assign fpu_b_o       = b_q;
  assign fpu_c_o       = c_q;
  assign fpu_op_o      = op_q;
  assign fpu_rm_o      = rm_q;
  assign irq_o         = sticky[FlDone] & ie_q;

endmodule

// File: tb/tb_fpu_wb_sequencer.sv
`timescale 1ns/1ps
module tb_fpu_wb_sequencer;
  import fpu_ctrl_pkg::*;

  localparam logic [31:0] Base = 32'h3000_0000;
  localparam logic [5:0]  RA = 6'h00, RB = 6'h04, RC = 6'h08, RRes = 6'h0C, RFlg = 6'h10;
  localparam logic [5:0]  RStat = 6'h14, RCtrl = 6'h18, ROp = 6'h1C, RRm = 6'h24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpu_wb_sequencer_if wbs ();

  logic [31:0] fpu_a, fpu_b, fpu_c, fpu_result;
  logic [11:0] fpu_op;
  logic [2:0]  fpu_rm;
  logic [4:0]  fpu_flags;
  logic        fpu_launch, fpu_vin, irq;

  logic        model_valid = 1'b0, man_valid = 1'b0;
  logic [31:0] model_res = '0, man_res = '0;
  logic [4:0]  model_flg = '0, man_flg = '0;
  int          model_delay = -1;

  assign fpu_vin    = model_valid | man_valid;
  assign fpu_result = man_valid ? man_res : model_res;
  assign fpu_flags  = man_valid ? man_flg : model_flg;

  fpu_wb_sequencer dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wbs          (wbs),
    .fpu_a_o      (fpu_a),
    .fpu_b_o      (fpu_b),
    .fpu_c_o      (fpu_c),
    .fpu_op_o     (fpu_op),
    .fpu_rm_o     (fpu_rm),
    .fpu_valid_o  (fpu_launch),
    .fpu_result_i (fpu_result),
    .fpu_flags_i  (fpu_flags),
    .fpu_valid_i  (fpu_vin),
    .irq_o        (irq)
  );

  int checks = 0;
  int errors = 0;
  int launches = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboards
  typedef struct {
    bit          is_read;
    logic [31:0] exp;
    string       name;
  } bus_exp_t;
  bus_exp_t bus_q[$];

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [11:0] op;
    logic [2:0]  rm;
  } launch_t;
  launch_t launch_q[$];

  // Bus monitor: compares read data on every ack
  initial begin
    bus_exp_t e;
    logic prev_ack;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (wbs.wbs_ack_o) begin
        check("ack_single_cycle", {31'b0, prev_ack}, 32'h0);
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ack expected none");
        end else begin
          e = bus_q.pop_front();
          if (e.is_read) check(e.name, wbs.wbs_dat_o, e.exp);
        end
      end
      prev_ack = wbs.wbs_ack_o;
    end
  end

  // Launch monitor: every fpu_valid_o cycle must match a queued launch
  initial begin
    launch_t l;
    forever begin
      @(negedge clk);
      if (fpu_launch) begin
        launches++;
        if (launch_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_launch: got op 0x%03h expected no launch", fpu_op);
        end else begin
          l = launch_q.pop_front();
          check("launch_a", fpu_a, l.a);
          check("launch_b", fpu_b, l.b);
          check("launch_c", fpu_c, l.c);
          check("launch_op", {20'b0, fpu_op}, {20'b0, l.op});
          check("launch_rm", {29'b0, fpu_rm}, {29'b0, l.rm});
        end
      end
    end
  end

  // FPU model: answers model_delay cycles after a launch (negative = never)
  initial begin
    int d;
    forever begin
      @(negedge clk);
      if (fpu_launch && model_delay >= 0) begin
        d = model_delay;
        repeat (d) @(posedge clk);
        #1 model_valid = 1'b1;
        @(posedge clk);
        #1 model_valid = 1'b0;
      end
    end
  end

  task automatic wb_xfer(input bit we, input logic [5:0] off, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [31:0] exp, input string name);
    bus_exp_t e;
    int n;
    e.is_read = !we;
    e.exp     = exp;
    e.name    = name;
    bus_q.push_back(e);
    wbs.wbs_adr_i = Base | {26'b0, off};
    wbs.wbs_dat_i = dat;
    wbs.wbs_sel_i = sel;
    wbs.wbs_we_i  = we;
    wbs.wbs_stb_i = 1'b1;
    wbs.wbs_cyc_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!wbs.wbs_ack_o && n < 16);
    wbs.wbs_stb_i = 1'b0;
    wbs.wbs_cyc_i = 1'b0;
    wbs.wbs_we_i  = 1'b0;
    if (!wbs.wbs_ack_o) begin
      checks++;
      errors++;
      $display("FAIL %s: got no ack expected ack within 16 cycles", name);
      void'(bus_q.pop_back());
    end
  endtask

  task automatic wr(input logic [5:0] off, input logic [31:0] dat);
    wb_xfer(1'b1, off, dat, 4'hF, 32'h0, "write");
  endtask

  task automatic rd(input logic [5:0] off, input logic [31:0] exp, input string name);
    wb_xfer(1'b0, off, 32'h0, 4'hF, exp, name);
  endtask

  task automatic expect_launch(input logic [11:0] op, input logic [2:0] rm);
    launch_t l;
    l.a  = 32'h3FC0_0000;
    l.b  = 32'h4000_0000;
    l.c  = 32'hFF00_FF00;
    l.op = op;
    l.rm = rm;
    launch_q.push_back(l);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    logic seen;
    wbs.wbs_stb_i = 1'b0;
    wbs.wbs_cyc_i = 1'b0;
    wbs.wbs_we_i  = 1'b0;
    wbs.wbs_sel_i = '0;
    wbs.wbs_adr_i = '0;
    wbs.wbs_dat_i = '0;

    // Reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ack", {31'b0, wbs.wbs_ack_o}, 32'h0);
    check("rst_dat", wbs.wbs_dat_o, 32'h0);
    check("rst_fpu_abc", fpu_a | fpu_b | fpu_c, 32'h0);
    check("rst_op_rm", {17'b0, fpu_op, fpu_rm}, 32'h0);
    check("rst_valid_irq", {30'b0, fpu_launch, irq}, 32'h0);
    rd(RStat, 32'h0, "rst_status");
    rd(RRes, 32'h0, "rst_result");

    // Byte lanes, unmapped offset, out-of-window access
    wb_xfer(1'b1, RC, 32'hFFFF_FFFF, 4'b1010, 32'h0, "write_c_sel");
    rd(RC, 32'hFF00_FF00, "c_sel_lanes");
    wr(6'h20, 32'h1234_5678);
    rd(6'h20, 32'h0, "unmapped_read");
    wbs.wbs_adr_i = 32'h3000_0100;
    wbs.wbs_we_i  = 1'b0;
    wbs.wbs_stb_i = 1'b1;
    wbs.wbs_cyc_i = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1 if (wbs.wbs_ack_o) seen = 1'b1;
    end
    wbs.wbs_stb_i = 1'b0;
    wbs.wbs_cyc_i = 1'b0;
    check("no_ack_outside", {31'b0, seen}, 32'h0);

    wr(RCtrl, 32'h1);
    rd(RCtrl, 32'h1, "ctrl_ie");

    // Multiply 1.5 * 2.0 = 3.0, with a busy write during WAIT
    wr(RA, 32'h3FC0_0000);
    wr(RB, 32'h4000_0000);
    wr(RRm, 32'h0);
    model_delay = 5;
    model_res   = 32'h4040_0000;
    model_flg   = 5'h00;
    expect_launch(OpMul, 3'd0);
    wr(ROp, 32'h1000 | {20'b0, OpMul});
    wr(RA, 32'hDEAD_BEEF);
    rd(RStat, 32'h5, "mul_busy_errbusy");
    repeat (10) @(posedge clk);
    #1;
    check("busy_write_discarded", fpu_a, 32'h3FC0_0000);
    check("irq_done_ie", {31'b0, irq}, 32'h1);
    rd(RRes, 32'h4040_0000, "mul_result");
    rd(RFlg, 32'h0, "mul_flags");
    rd(ROp, {20'b0, OpMul}, "op_start_reads_0");
    rd(RStat, 32'h6, "mul_status");
    wr(RStat, 32'h4);
    rd(RStat, 32'h2, "errbusy_cleared");

    // Non-one-hot op
    wr(ROp, 32'h1003);
    rd(RStat, 32'hA, "bad_op_status");
    rd(ROp, 32'h003, "bad_op_latched");
    wr(RStat, 32'hA);
    rd(RStat, 32'h0, "status_cleared");
    #1 check("irq_cleared", {31'b0, irq}, 32'h0);

    // Timeout: model never answers
    model_delay = -1;
    expect_launch(OpAdd, 3'd0);
    wr(ROp, 32'h1000 | {20'b0, OpAdd});
    repeat (55) @(posedge clk);
    #1;
    rd(RStat, 32'h1, "still_busy_before_timeout");
    repeat (15) @(posedge clk);
    #1;
    rd(RStat, 32'h10, "timeout_status");
    rd(RRes, 32'h4040_0000, "timeout_result_kept");
    wr(RStat, 32'h10);

    // Next launch after timeout
    wr(RRm, 32'h3);
    rd(RRm, 32'h3, "rm_rw");
    model_delay = 2;
    model_res   = 32'h4120_0000;
    model_flg   = 5'h01;
    expect_launch(OpSub, 3'd3);
    wr(ROp, 32'h1000 | {20'b0, OpSub});
    repeat (10) @(posedge clk);
    #1;
    rd(RRes, 32'h4120_0000, "relaunch_result");
    rd(RFlg, 32'h1, "relaunch_flags");
    rd(RStat, 32'h2, "relaunch_status");

    // W1C of done in the same cycle as the result strobe: set wins
    model_delay = -1;
    expect_launch(OpMul, 3'd3);
    wr(ROp, 32'h1000 | {20'b0, OpMul});
    rd(RFlg, 32'h0, "flags_cleared_on_launch");
    repeat (3) @(posedge clk);
    #1;
    man_res = 32'h3F80_0000;
    man_flg = 5'h00;
    fork
      wr(RStat, 32'h2);
      begin
        man_valid = 1'b1;
        @(posedge clk);
        #1 man_valid = 1'b0;
      end
    join
    rd(RStat, 32'h2, "w1c_vs_set_done");
    rd(RRes, 32'h3F80_0000, "w1c_vs_set_result");

    // Reset during WAIT, late result afterwards
    model_delay = 8;
    model_res   = 32'h40A0_0000;
    expect_launch(OpMul, 3'd3);
    wr(ROp, 32'h1000 | {20'b0, OpMul});
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("rst_wait_fpu_a", fpu_a, 32'h0);
    check("rst_wait_irq", {31'b0, irq}, 32'h0);
    rd(RStat, 32'h0, "late_valid_status");
    rd(RRes, 32'h0, "late_valid_result");

    repeat (2) @(posedge clk);
    #1;
    check("launch_count", launches, 32'd5);
    check("launch_queue_empty", launch_q.size(), 32'd0);
    check("bus_queue_empty", bus_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
